// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - execute-stage handshake between the pipeline and the multiply/divide unit
interface md_sequencer_if #(
    parameter int D_WIDTH = 32
);
    logic               start;
    logic               flush;
    logic [2:0]         md_op;
    logic [D_WIDTH-1:0] op_a;
    logic [D_WIDTH-1:0] op_b;
    logic [D_WIDTH-1:0] result;
    logic               done;
    logic               busy;
    logic               stall;

    modport master (
        output start, flush, md_op, op_a, op_b,
        input  result, done, busy, stall
    );

    modport slave (
        input  start, flush, md_op, op_a, op_b,
        output result, done, busy, stall
    );
endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative RV32M shift-add multiply / restoring divide with pipeline stall
module md_sequencer #(
    parameter int D_WIDTH = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    md_sequencer_if.slave   io_md
);
    localparam int CW = $clog2(D_WIDTH);
    localparam int W  = D_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [W-1:0]       r_opnd;      // multiplicand or divisor magnitude
    logic [2*W-1:0]     r_acc;       // {hi, lo} product, or {remainder, quotient}
    logic               r_neg_main;  // negate product / quotient at the end
    logic               r_neg_rem;   // negate remainder at the end
    logic [W-1:0]       r_result;
    logic               r_done;

    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [W:0]         w_mul_sum;
    logic [2*W-1:0]     w_mul_next;
    logic [W:0]         w_shift;
    logic [W:0]         w_diff;
    logic [2*W-1:0]     w_div_next;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quo;
    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_fin;

    assign w_accept = (r_state == ST_IDLE) & io_md.start & ~r_done & ~io_md.flush;

    // Signed operands: op_a is signed for MUL/MULH/MULHSU/DIV/REM, op_b for MUL/MULH/DIV/REM.
    assign w_sign_a = io_md.op_a[W-1] & (io_md.md_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    assign w_sign_b = io_md.op_b[W-1] & (io_md.md_op inside {3'd0, 3'd1, 3'd4, 3'd6});
    assign w_mag_a  = w_sign_a ? -io_md.op_a : io_md.op_a;
    assign w_mag_b  = w_sign_b ? -io_md.op_b : io_md.op_b;

    // One shift-add multiply step: add multiplicand into the high half when the low bit is set.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // One restoring divide step: shift in the next dividend bit, subtract when it fits.
    assign w_shift    = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_div_next = w_diff[W] ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                  : {w_diff[W-1:0],  r_acc[W-2:0], 1'b1};

    // Sign correction and result selection for the final edge.
    always_comb begin
        w_prod = r_neg_main ? -r_acc : r_acc;
        w_quo  = r_neg_main ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        case (r_op)
            3'd0:                w_fin = w_prod[W-1:0];
            3'd1, 3'd2, 3'd3:    w_fin = w_prod[2*W-1:W];
            3'd4, 3'd5:          w_fin = w_quo;
            default:             w_fin = w_rem;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; flush always returns to idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_CALC;
            ST_CALC: if (r_cnt == '0) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (io_md.flush) w_next = ST_IDLE;
    end

    // Datapath: operand capture, iteration, and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!io_md.flush) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_op      <= io_md.md_op;
                            r_cnt     <= CW'(D_WIDTH - 1);
                            r_neg_rem <= w_sign_a;
                            if (io_md.md_op[2]) begin
                                r_opnd     <= w_mag_b;
                                r_acc      <= {{W{1'b0}}, w_mag_a};
                                // Divide by zero keeps the all-ones quotient unsigned.
                                r_neg_main <= (w_sign_a ^ w_sign_b) & (io_md.op_b != '0);
                            end else begin
                                r_opnd     <= w_mag_a;
                                r_acc      <= {{W{1'b0}}, w_mag_b};
                                r_neg_main <= w_sign_a ^ w_sign_b;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    end
                    ST_FIN: begin
                        r_result <= w_fin;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_md.result = r_result;
    assign io_md.done   = r_done;
    assign io_md.busy   = (r_state != ST_IDLE);
    assign io_md.stall  = (io_md.start & ~r_done & ~io_md.flush) | (r_state != ST_IDLE);
endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer
module tb_md_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_sequencer_if #(.D_WIDTH(W)) bus ();

    md_sequencer #(.D_WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_md (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference arithmetic for the M extension, from plain integer math.
    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Timing model: an accepted op finishes W+1 edges later; flush cancels; done cycle ignores start.
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic        m_nd;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pending = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem    = 0;
            m_done   = 1'b0;
            m_result = 32'd0;
        end else begin
            m_nd = 1'b0;
            if (bus.flush) begin
                m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_nd     = 1'b1;
                    m_result = m_pending;
                end
            end else if (bus.start && !m_done) begin
                m_rem     = W + 1;
                m_pending = md_ref(bus.md_op, bus.op_a, bus.op_b);
            end
            m_done = m_nd;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy",   32'(bus.busy), 32'(m_rem > 0));
            check("cyc done",   32'(bus.done), 32'(m_done));
            check("cyc stall",  32'(bus.stall),
                  32'((bus.start & ~m_done & ~bus.flush) | (m_rem > 0)));
            check("cyc result", bus.result, m_result);
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int n;
        int stall_low;
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.op_a = a; bus.op_b = b;
        @(posedge clk);
        #1;
        bus.op_a = $urandom; bus.op_b = $urandom; bus.md_op = 3'($urandom);
        n = 0; got = 1'b0; stall_low = 0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done) got = 1'b1;
            else if (!bus.stall) stall_low++;
        end
        check({name, " latency"}, 32'(n), 32'd33);
        check({name, " stall held"}, 32'(stall_low), 32'd0);
        check({name, " result"}, bus.result, exp);
        check({name, " model"}, m_result, exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, " no relaunch"}, 32'(bus.busy), 32'd0);
        check({name, " single done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.md_op = 3'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset result", bus.result, 32'd0);
        check("reset done",   32'(bus.done), 32'd0);
        check("reset busy",   32'(bus.busy), 32'd0);
        check("reset stall",  32'(bus.stall), 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM -7/2");
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        "DIVU 100/7");
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         "REMU 100/7");
        run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "DIVU 5/0");
        run_op(3'd7, 32'd5,         32'd0,         32'd5,         "REMU 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "REM ovf");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "DIV -7/0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "REM -7/0");
        run_op(3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "MUL wrap");

        // Flush at accept+10.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd6;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush busy",  32'(bus.busy), 32'd0);
        check("flush stall", 32'(bus.stall), 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("flush no done", 32'(dones), 32'd0);
        check("flush result kept", bus.result, 32'h000B_000F);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "MUL 3*4 after flush");

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'd4; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst result", bus.result, 32'd0);
        check("midrst done",   32'(bus.done), 32'd0);
        check("midrst busy",   32'(bus.busy), 32'd0);
        check("midrst stall",  32'(bus.stall), 32'd0);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("midrst no done", 32'(dones), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
